// File: rtl/dmem_lsu.sv
// Load/store unit between the MEM-stage strobes and the single-port data SRAM.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module dmem_lsu #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_cs,
  input  logic [3:0]        req_we,
  input  logic              req_oe,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              misalign,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic [3:0]        sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [31:0]       sram_di,
  input  logic [31:0]       sram_do
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, ERR} state_t;

  state_t              state;
  logic [2:0]          f3_q;
  logic [1:0]          off_q;
  logic                sram_cs_q;
  logic                sram_oe_q;
  logic [3:0]          sram_web_q;
  logic [ADDR_W-1:0]   sram_a_q;
  logic [31:0]         sram_di_q;
  logic                rvalid_q;
  logic                misalign_q;

  logic                is_store;
  logic                is_load;
  logic                accept;
  logic                size_b;
  logic                size_h;
  logic                size_w;
  logic                bad_align;
  logic [3:0]          web_fmt;
  logic [31:0]         di_fmt;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_fmt;
  logic                unused_addr;

  assign unused_addr = ^addr[31:ADDR_W+2];

  assign is_store = (req_we != 4'b1111);
  assign is_load  = !is_store && req_oe;
  assign accept   = (state == IDLE) && req_cs && (is_store || is_load);

  // funct3[1:0] selects the size; the reserved encodings fall through to word.
  assign size_b = (funct3[1:0] == 2'b00);
  assign size_h = (funct3[1:0] == 2'b01);
  assign size_w = !size_b && !size_h;

`ifdef MISALIGN_TRAP_EN
  assign bad_align = (size_h && addr[0]) || (size_w && (addr[1:0] != 2'b00));
`else
  assign bad_align = 1'b0;
`endif

  always_comb begin
    web_fmt = 4'b0000;
    di_fmt  = wdata;
    if (size_b) begin
      web_fmt = ~(4'b0001 << addr[1:0]);
      di_fmt  = {4{wdata[7:0]}};
    end else if (size_h) begin
      web_fmt = ~(4'b0011 << {addr[1], 1'b0});
      di_fmt  = {2{wdata[15:0]}};
    end
  end

  always_comb begin
    ld_byte = sram_do[7:0];
    case (off_q)
      2'd1:    ld_byte = sram_do[15:8];
      2'd2:    ld_byte = sram_do[23:16];
      2'd3:    ld_byte = sram_do[31:24];
      default: ld_byte = sram_do[7:0];
    endcase
    ld_half = off_q[1] ? sram_do[31:16] : sram_do[15:0];
    case (f3_q[1:0])
      2'b00:   ld_fmt = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_fmt = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
      default: ld_fmt = sram_do;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      sram_cs_q  <= 1'b0;
      sram_oe_q  <= 1'b0;
      sram_web_q <= 4'b1111;
      sram_a_q   <= '0;
      sram_di_q  <= 32'd0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            f3_q  <= funct3;
            off_q <= addr[1:0];
            if (bad_align) begin
              state      <= ERR;
              misalign_q <= 1'b1;
            end else if (is_store) begin
              state      <= WRITE;
              sram_cs_q  <= 1'b1;
              sram_oe_q  <= 1'b0;
              sram_web_q <= web_fmt;
              sram_a_q   <= addr[ADDR_W+1:2];
              sram_di_q  <= di_fmt;
            end else begin
              state      <= READ;
              sram_cs_q  <= 1'b1;
              sram_oe_q  <= 1'b1;
              sram_web_q <= 4'b1111;
              sram_a_q   <= addr[ADDR_W+1:2];
            end
          end
        end
        WRITE: begin
          state      <= IDLE;
          sram_cs_q  <= 1'b0;
          sram_web_q <= 4'b1111;
        end
        READ: begin
          state     <= RESP;
          sram_cs_q <= 1'b0;
          sram_oe_q <= 1'b0;
          rvalid_q  <= 1'b1;
        end
        RESP: begin
          state    <= IDLE;
          rvalid_q <= 1'b0;
        end
        ERR: begin
          state      <= IDLE;
          misalign_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding rst low kills any strobe in flight before the reset edge lands.
  assign sram_cs  = sram_cs_q & rst;
  assign sram_oe  = sram_oe_q & rst;
  assign sram_web = sram_web_q | {4{~rst}};
  assign sram_a   = sram_a_q;
  assign sram_di  = sram_di_q;
  assign stall    = rst && (accept || (state == READ));
  assign rvalid   = rvalid_q & rst;
  assign rdata    = rvalid ? ld_fmt : 32'd0;

`ifdef MISALIGN_TRAP_EN
  assign misalign = misalign_q & rst;
`else
  logic unused_trap;
  assign unused_trap = misalign_q;
  assign misalign    = 1'b0;
`endif

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit between the core's MEM-stage memory strobes and the single-port data SRAM wrapper. It accepts one request per access (chip select, write enable, output enable, funct3, address, store data) and drives the SRAM with active-low byte-lane write enables and replicated store data. On loads it extracts and sign- or zero-extends the byte, halfword or word and returns it with a valid pulse. It holds the pipeline via stall while the SRAM access is in flight.

Parameters:
ADDR_W, 14, SRAM word-address width; sram_a = addr[ADDR_W+1:2]

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-low reset
req_cs  in  1  memory request strobe from decode
req_we  in  4  4'b1111 = read; any other value = store
req_oe  in  1  load output enable; required for a load
funct3  in  3  000 B, 001 H, 010 W, 100 BU (load), 101 HU (load)
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rs2)
stall  out  1  hold MEM stage and earlier
rdata  out  32  formatted load data
rvalid  out  1  rdata valid this cycle
misalign  out  1  misaligned access pulse (see Optional Feature)
sram_cs  out  1  SRAM chip select
sram_oe  out  1  SRAM output enable
sram_web  out  4  SRAM byte write enables, active-low
sram_a  out  ADDR_W  SRAM word address
sram_di  out  32  SRAM write data
sram_do  in  32  SRAM read data, valid one cycle after a read strobe

Behaviour:
- States: IDLE, WRITE, READ, RESP, ERR. Reset -> IDLE.
- Reset values: stall=0, rvalid=0, rdata=0, misalign=0, sram_cs=0, sram_oe=0, sram_web=4'b1111, sram_a=0, sram_di=0. While rst=0, all SRAM strobes are masked combinationally, so a write in flight is suppressed. After the reset edge the block is in IDLE.
- Request latch: in IDLE with req_cs=1, latch addr, wdata, funct3 and kind, and drive stall=1 combinationally that cycle (T0).
  - Store (req_we!=1111) -> WRITE.
  - Load (req_we==1111 and req_oe=1) -> READ.
  - req_cs=1 with req_we=1111 and req_oe=0 is a no-op: stall=0, state stays IDLE.
- WRITE (T1): sram_cs=1, sram_oe=0, sram_a and sram_web/sram_di drive the formatted store; stall=0 -> IDLE.
- READ (T1): sram_cs=1, sram_oe=1, sram_web=1111; stall=1 -> RESP.
- RESP (T2): rvalid=1, rdata=formatted sram_do, stall=0 -> IDLE. In all other states rdata=0.
- Request ignore rule: in WRITE/RESP/ERR, req_cs is ignored; it is the same instruction, already accepted.
- Latency: store stalls 1 cycle; load stalls 2 cycles with data at T2. Back-to-back accesses are spaced by at least one non-IDLE cycle.
- Store formatting (off=addr[1:0]):
  - B: web=~(4'b0001<<off), di={4{wdata[7:0]}}.
  - H: web=~(4'b0011<<{off[1],0}), di={2{wdata[15:0]}}.
  - W: web=4'b0000, di=wdata.
- Load formatting:
  - B/BU: byte at off, sign-/zero-extended.
  - H/HU: half at off[1], sign-/zero-extended.
  - W: full word.
- funct3 011/110/111 are treated as W.
- Outside WRITE/READ: sram_cs=0, sram_oe=0, sram_web=1111.

Optional Feature:
Macro: MISALIGN_TRAP_EN.
- Defined: H with off[0]=1 or W with off!=0 performs no SRAM access. IDLE -> ERR, with stall=1 at T0. ERR lasts one cycle with misalign=1, stall=0, rvalid=0, then returns to IDLE.
- Undefined: misalign tied 0; H ignores off[0], W ignores off[1:0] (forced alignment); ERR unreachable.

Test Plan:
- SB addr=0x103 wdata=0xA5 -> T0 stall=1; T1 sram_cs=1 sram_a=0x040 sram_web=4'b0111 sram_di=0xA5A5A5A5 stall=0.
- LB addr=0x103, sram_do=0x80112233 at T2 -> rdata=0xFFFFFF80 rvalid=1; LBU same -> 0x00000080; LHU addr=0x102 -> 0x00008011; LH addr=0x102 -> 0xFFFF8011.
- SW 0x200 0xDEADBEEF then LW 0x200 with SRAM model -> store web=0000 a=0x080; load rdata=0xDEADBEEF at T2; stall pattern 1,0,1,1,0.
- Load with req_oe=0 (req_we=1111) -> no SRAM strobe, stall=0, state stays IDLE.
- rst=0 asserted during READ -> sram_cs=0 that cycle, next cycle IDLE, rvalid never pulses, all outputs at reset values.
- MISALIGN_TRAP_EN defined, LW addr=0x102 -> misalign=1 one cycle at T1, no sram_cs; undefined -> reads sram_a=0x040, rvalid at T2.
